mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Round-robin arbiter sharing one memory port among 4 requesters.
// - Generates the 2-bit sel_o that steers a 4:1 mux onto the memory
//   addr/wdata/we bus, and sequences each transaction with a
//   valid/ready handshake to memory.
// - Returns a per-requester done pulse.
// - Sits between the memtest traffic generators and the data memory.
// PARAMETERS
// - ADDR_WIDTH      32   memory address width (informational, for mux sizing)
// - TIMEOUT_CYCLES  64   BUSY cycles before abort; used only with ARB_TIMEOUT_EN
// PORTS
// - clk_i          in   1  clock; all state changes on rising edge
// - rst_ni         in   1  synchronous reset, active-low
// - req_i          in   4  request per requester; held high until its done_o
// - mem_ready_i    in   1  memory has completed the current access
// - sel_o          out  2  index of granted requester; drives the mux select
// - gnt_o          out  4  one-hot grant; 0 when idle
// - mem_valid_o    out  1  access in flight; held until mem_ready_i
// - done_o         out  4  one-cycle completion pulse, one-hot
// - err_o          out  1  one-cycle pulse alongside done_o when the access timed out
// BEHAVIOUR
// - Reset (rst_ni low at a clock edge):
//   - state=IDLE, sel_o=0, gnt_o=0, mem_valid_o=0, done_o=0, err_o=0.
//   - last=3, so requester 0 has top priority first.
//   - Applies mid-transaction: the in-flight access is abandoned and no done_o is issued.
// - FSM states: IDLE, BUSY, DONE.
// - IDLE:
//   - If req_i != 0, pick the first set bit scanning last+1, last+2, ... (mod 4).
//   - Next cycle: state=BUSY, sel_o=winner, gnt_o=1<<winner, mem_valid_o=1.
//   - If req_i == 0, outputs hold their reset values.
// - BUSY:
//   - sel_o, gnt_o and mem_valid_o are stable.
//   - req_i changes are ignored; a dropped req still completes.
//   - mem_ready_i=1 -> next cycle:
//     - state=DONE, mem_valid_o=0, gnt_o=0;
//     - done_o=1<<sel_o, last=sel_o.
// - DONE (exactly 1 cycle):
//   - done_o is high; no arbitration.
//   - Next cycle: state=IDLE, done_o=0.
//   - The requester must drop or renew req_i by the end of DONE.
// - Latency:
//   - req at cycle 0 (IDLE) -> mem_valid_o at cycle 1.
//   - mem_ready_i at cycle N -> done_o at N+1.
//   - Earliest next grant: mem_valid_o at N+3.
// - sel_o keeps its last value outside BUSY; only the gnt_o=0 / mem_valid_o=0 state is meaningful there.
// - mem_ready_i outside BUSY is ignored.
// - Fairness: a continuously requesting requester waits at most 3 other transactions.
// CONFIGURATION
// - Macro ARB_TIMEOUT_EN defined:
//   - A counter clears on BUSY entry and increments each BUSY cycle without mem_ready_i.
//   - When it reaches TIMEOUT_CYCLES-1 with mem_ready_i still low, next cycle: state=DONE,
//     done_o=1<<sel_o, err_o=1, last=sel_o.
//   - mem_ready_i on that same cycle wins: normal completion, err_o=0.
// - Macro ARB_TIMEOUT_EN undefined:
//   - No counter; BUSY waits indefinitely.
//   - err_o is tied to 0.
// TESTING
// - Reset, req_i=4'b0000 -> gnt_o=0, mem_valid_o=0, sel_o=0 every cycle.
// - After reset, req_i=4'b1111, mem_ready_i 2 cycles after each grant, requesters drop req on done
//   -> grant order 0,1,2,3; done_o=0001,0010,0100,1000.
// - last=1, req_i=4'b1001 -> sel_o=3, gnt_o=1000; next round sel_o=0.
// - req_i=4'b0100, mem_ready_i at cycle 5 -> mem_valid_o cycles 1-5, done_o=0100 at cycle 6,
//   IDLE at cycle 7; req dropped in cycle 3 still completes.
// - rst_ni low for 1 cycle while BUSY -> all outputs 0 next cycle, no done_o, next grant goes to
//   requester 0 first.
// - ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready_i held 0 -> done_o and err_o high 8 cycles after
//   grant; without the macro, mem_valid_o stays high for 100 cycles.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among four requesters, with a
// valid/ready handshake to memory. Define ARB_TIMEOUT_EN to abort stalled accesses.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] req_i,
  input  logic       mem_ready_i,
  output logic [1:0] sel_o,
  output logic [3:0] gnt_o,
  output logic       mem_valid_o,
  output logic [3:0] done_o,
  output logic       err_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] state;
  logic [1:0] last;
  logic [1:0] winner;
  logic       found;
  logic       timeout;
  logic       complete;

  // ADDR_WIDTH only sizes the external mux; referenced here to keep it visible.
  logic unused_cfg;
  assign unused_cfg = (ADDR_WIDTH > 0) ^ (TIMEOUT_CYCLES > 0);

  // Scan starts one past the previous winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = last;
    for (int i = 1; i <= 4; i++) begin
      if (!found && req_i[last + 2'(i)]) begin
        found  = 1'b1;
        winner = last + 2'(i);
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] busy_cnt;
  logic             err_q;

  assign timeout = (state == BUSY) && !mem_ready_i && (busy_cnt == CNT_MAX);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      busy_cnt <= '0;
    end else if (state == IDLE && found) begin
      busy_cnt <= '0;
    end else if (state == BUSY && !mem_ready_i && !timeout) begin
      busy_cnt <= busy_cnt + 1'b1;
    end
  end

  // A ready arriving on the last allowed cycle suppresses the error flag.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  assign complete = mem_ready_i || timeout;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      last        <= 2'd3;
      sel_o       <= 2'd0;
      gnt_o       <= 4'b0000;
      mem_valid_o <= 1'b0;
      done_o      <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state       <= BUSY;
            sel_o       <= winner;
            gnt_o       <= 4'b0001 << winner;
            mem_valid_o <= 1'b1;
          end
        end
        BUSY: begin
          if (complete) begin
            state       <= DONE;
            gnt_o       <= 4'b0000;
            mem_valid_o <= 1'b0;
            done_o      <= 4'b0001 << sel_o;
            last        <= sel_o;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_o <= 4'b0000;
        end
        default: begin
          state       <= IDLE;
          gnt_o       <= 4'b0000;
          mem_valid_o <= 1'b0;
          done_o      <= 4'b0000;
        end
      endcase
    end
  end

  // Structural invariants of the grant/handshake outputs.
  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_done_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(done_o));
  a_valid_gnt: assert property (@(posedge clk_i) disable iff (!rst_ni) mem_valid_o == (gnt_o != 4'b0000));
  a_no_overlap: assert property (@(posedge clk_i) disable iff (!rst_ni) !(mem_valid_o && (done_o != 4'b0000)));

endmodule
